// File: rtl/arbitro_rr_multicanal_pkg.sv
// Shared types and width helpers for the multichannel round-robin arbiter.
package arbitro_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_SERVE = 1'b1} state_t;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;

  // counter able to hold 0..n inclusive
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // index into n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_rr_multicanal_rr_next_sel.sv
// Next-channel finder: cyclic search from start (round-robin) or lowest index (priority).
module rr_next_sel
  import arbitro_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int GW     = idx_w(NUM_CH)
)(
  input  logic [NUM_CH-1:0] avail,
  input  logic [GW-1:0]     start,
  input  logic              mode,
  output logic [GW-1:0]     idx,
  output logic              found
);

  logic [GW-1:0] j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    // walk from the far end so the nearest hit is the last one written
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (mode == MODE_PRIO) ? GW'(k) : GW'((int'(start) + k) % NUM_CH);
      if (avail[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_multicanal.sv
// Drains NUM_CH show-ahead input FIFOs into one downstream FIFO with burst-limited
// round-robin or strict priority, tracking per-channel occupancy from push/pop traffic.
module arbitro_rr_multicanal
  import arbitro_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
)(
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [NUM_CH-1:0]        push_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     down_almost_full,
  input  logic                     mode,
  output logic [NUM_CH-1:0]        pop,
  output logic                     push_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [idx_w(NUM_CH)-1:0] grant_ch,
  output logic                     idle,
  output logic                     ovf_err
);

  localparam int CW = cnt_w(DEPTH);
  localparam int GW = idx_w(NUM_CH);
  localparam int BW = cnt_w(MAX_BURST);

  state_t                        state, state_nxt;
  logic [NUM_CH-1:0][CW-1:0]     count, count_nxt;
  logic [NUM_CH-1:0][DATA_W-1:0] head;
  logic [NUM_CH-1:0]             avail, ovf_hit;
  logic [BW-1:0]                 burst, burst_nxt;
  logic [GW-1:0]                 start, nxt_idx, sel;
  logic                          found, keep, issue;

  assign head = data_in;

  // the in-flight pop is already spoken for, so it does not count as available
  always_comb begin
    ovf_hit   = '0;
    count_nxt = '0;
    avail     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ovf_hit[i]   = push_in[i] && (count[i] == CW'(DEPTH));
      count_nxt[i] = count[i] - CW'(pop[i]) + CW'(push_in[i] && !ovf_hit[i]);
      avail[i]     = (count[i] - CW'(pop[i])) != '0;
    end
  end

  // from IDLE the search includes the last grant; in SERVE it starts one past it
  always_comb begin
    start = grant_ch;
    if (state == ST_SERVE)
      start = (grant_ch == GW'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
  end

  rr_next_sel #(.NUM_CH(NUM_CH), .GW(GW)) u_sel (
    .avail (avail),
    .start (start),
    .mode  (mode),
    .idx   (nxt_idx),
    .found (found)
  );

  always_ff @(posedge clk) begin
    if (!reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (found && !down_almost_full)  state_nxt = ST_SERVE;
      ST_SERVE: if (!found && !down_almost_full) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    keep      = (state == ST_SERVE) && (mode == MODE_RR) && avail[grant_ch] &&
                (burst < BW'(MAX_BURST));
    issue     = !down_almost_full && found;
    sel       = keep ? grant_ch : nxt_idx;
    burst_nxt = burst;
    if (issue) begin
      if (keep || ((state == ST_SERVE) && (mode == MODE_PRIO) && (sel == grant_ch)))
        burst_nxt = (burst < BW'(MAX_BURST)) ? burst + 1'b1 : burst;
      else
        burst_nxt = BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      count    <= '0;
      burst    <= '0;
      pop      <= '0;
      push_out <= 1'b0;
      data_out <= '0;
      grant_ch <= '0;
      idle     <= 1'b1;
      ovf_err  <= 1'b0;
    end else begin
      count    <= count_nxt;
      burst    <= burst_nxt;
      pop      <= issue ? (NUM_CH'(1) << sel) : '0;
      push_out <= issue;
      idle     <= !issue && (count_nxt == '0);
      ovf_err  <= ovf_err || (|ovf_hit);
      if (issue) begin
        data_out <= head[sel];
        grant_ch <= sel;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_rr_multicanal.sv
// Directed bench: input FIFO model drives data_in, scoreboard holds the predicted pop order.
module tb_arbitro_rr_multicanal;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 10;
  localparam int DEPTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int GW        = $clog2(NUM_CH);

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset_L = 1'b0;
  logic                     down_almost_full = 1'b0;
  logic                     mode = 1'b0;
  logic [NUM_CH-1:0]        push_in = '0;
  logic [NUM_CH*DATA_W-1:0] data_in = '0;
  logic [NUM_CH-1:0]        pop;
  logic                     push_out;
  logic [DATA_W-1:0]        data_out;
  logic [GW-1:0]            grant_ch;
  logic                     idle;
  logic                     ovf_err;

  logic [NUM_CH-1:0][DATA_W-1:0] wdat = '0;
  logic [DATA_W-1:0]             fq   [NUM_CH][$];
  logic [DATA_W-1:0]             pend [NUM_CH][$];
  exp_t                          sb   [$];
  logic [DATA_W-1:0]             seq = 10'h101;
  logic [DATA_W-1:0]             w;
  int                            checks = 0;
  int                            errors = 0;

  always #5 clk = ~clk;

  arbitro_rr_multicanal #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .push_in          (push_in),
    .data_in          (data_in),
    .down_almost_full (down_almost_full),
    .mode             (mode),
    .pop              (pop),
    .push_out         (push_out),
    .data_out         (data_out),
    .grant_ch         (grant_ch),
    .idle             (idle),
    .ovf_err          (ovf_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one push cycle on every channel in m, each with a fresh data word
  task automatic put(input logic [NUM_CH-1:0] m);
    for (int i = 0; i < NUM_CH; i++)
      if (m[i]) begin
        wdat[i] = seq;
        pend[i].push_back(seq);
        seq = seq + 1'b1;
      end
    push_in = m;
    tick();
    push_in = '0;
  endtask

  task automatic expect_n(input int ch, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ch   = ch;
      e.data = pend[ch].pop_front();
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
    chk({tag, "_drain"}, sb.size(), 0);
    chk({tag, "_idle"}, idle, 1'b1);
  endtask

  // scoreboard compare, then input FIFO model update (show-ahead, pop consumed this cycle)
  always @(negedge clk) begin
    exp_t e;
    chk("pop_vs_push", {31'b0, |pop}, {31'b0, push_out});
    if (push_out === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_word", push_out, 1'b0);
      else begin
        e = sb.pop_front();
        chk("pop_ch", pop, NUM_CH'(1) << e.ch);
        chk("grant_ch", grant_ch, e.ch);
        chk("data_out", data_out, e.data);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop[i] === 1'b1 && fq[i].size() > 0) fq[i].delete(0);
      if (push_in[i] === 1'b1) fq[i].push_back(wdat[i]);
      data_in[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_pop", pop, 0);
    chk("rst_push_out", push_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_grant", grant_ch, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", ovf_err, 0);
    reset_L = 1'b1;
    tick();

    // single word on ch2: pop exactly two cycles after the push
    w = seq;
    put(4'b0100);
    expect_n(2, 1);
    chk("t1_c1_pop", pop, 0);
    chk("t1_c1_idle", idle, 0);
    tick();
    chk("t1_pop", pop, 4'b0100);
    chk("t1_push_out", push_out, 1);
    chk("t1_data", data_out, w);
    tick();
    chk("t1_c3_pop", pop, 0);
    chk("t1_c3_idle", idle, 1);

    // burst limit: ch0 x4, ch1 x2, ch0 x2, no bubbles
    down_almost_full = 1'b1;
    put(4'b0011);
    put(4'b0011);
    repeat (4) put(4'b0001);
    expect_n(0, 4);
    expect_n(1, 2);
    expect_n(0, 2);
    down_almost_full = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("t2_b2b", push_out, 1);
      tick();
    end
    chk("t2_end", push_out, 0);
    chk("t2_idle", idle, 1);

    // empty channels skipped: ch1 x4, ch3 x4, ch1, ch3
    down_almost_full = 1'b1;
    repeat (5) put(4'b1010);
    expect_n(1, 4);
    expect_n(3, 4);
    expect_n(1, 1);
    expect_n(3, 1);
    down_almost_full = 1'b0;
    drain("t3");
    chk("t3_grant", grant_ch, 3);

    // strict priority: refilled ch0 finishes before any ch3 word
    down_almost_full = 1'b1;
    mode = 1'b1;
    repeat (3) put(4'b1001);
    expect_n(0, 3);
    down_almost_full = 1'b0;
    tick();
    put(4'b0001);
    expect_n(0, 1);
    expect_n(3, 3);
    drain("t4");

    // backpressure mid-burst: burst count survives the stall
    mode = 1'b0;
    down_almost_full = 1'b1;
    repeat (6) put(4'b0100);
    expect_n(2, 4);
    down_almost_full = 1'b0;
    tick();
    chk("t5_pop_a", pop, 4'b0100);
    tick();
    chk("t5_pop_b", pop, 4'b0100);
    down_almost_full = 1'b1;
    put(4'b1000);
    expect_n(3, 1);
    expect_n(2, 2);
    chk("t5_stall1", pop, 0);
    tick();
    chk("t5_stall2", pop, 0);
    chk("t5_grant_hold", grant_ch, 2);
    tick();
    chk("t5_stall3", pop, 0);
    down_almost_full = 1'b0;
    tick();
    chk("t5_resume", pop, 4'b0100);
    drain("t5");

    // overflow: ninth push to a full ch0 is dropped and flagged
    down_almost_full = 1'b1;
    repeat (8) put(4'b0001);
    chk("t6_ovf_at_full", ovf_err, 0);
    put(4'b0001);
    chk("t6_ovf_set", ovf_err, 1);
    chk("t6_not_idle", idle, 0);
    expect_n(0, 8);
    down_almost_full = 1'b0;
    drain("t6");
    chk("t6_ovf_sticky", ovf_err, 1);

    // reset mid-burst drops the pending pop and clears the flag
    put(4'b0010);
    expect_n(1, 1);
    put(4'b0010);
    chk("t7_pop", pop, 4'b0010);
    reset_L = 1'b0;
    tick();
    chk("t7_rst_pop", pop, 0);
    chk("t7_rst_push_out", push_out, 0);
    chk("t7_rst_data_out", data_out, 0);
    chk("t7_rst_grant", grant_ch, 0);
    chk("t7_rst_idle", idle, 1);
    chk("t7_rst_ovf", ovf_err, 0);
    reset_L = 1'b1;
    sb.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      fq[i].delete();
      pend[i].delete();
    end
    tick();
    tick();
    chk("t7_post_pop", pop, 0);
    chk("t7_post_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_multicanal.md
# arbitro_rr_multicanal

Parametrised round-robin arbiter for the transaction layer. It drains NUM_CH show-ahead input FIFOs into one downstream FIFO. Per-channel occupancy is tracked internally from push/pop traffic. Adds burst limiting, a strict-priority mode and downstream backpressure. It sits between the per-class input FIFOs and the single downstream FIFO.

## Interface
- NUM_CH, 4: number of input channels (≥2)
- DATA_W, 10: word width
- DEPTH, 8: depth of each input FIFO; occupancy counters are $clog2(DEPTH+1) bits wide
- MAX_BURST, 4: maximum consecutive pops from one channel in round-robin mode (≥1)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset_L  in  1  reset, synchronous, active-low
- push_in  in  NUM_CH  per-channel push strobe into each input FIFO
- data_in  in  NUM_CH*DATA_W  head word of each input FIFO; channel i occupies bits [i*DATA_W +: DATA_W]
- down_almost_full  in  1  downstream backpressure
- mode  in  1  0 = round-robin with burst limit, 1 = strict priority (channel 0 highest)
- pop  out  NUM_CH  registered, one-hot or zero; pop strobe to the input FIFOs
- push_out  out  1  registered; write strobe to the downstream FIFO
- data_out  out  DATA_W  registered; word being written downstream
- grant_ch  out  $clog2(NUM_CH)  registered; channel currently served
- idle  out  1  registered; all counters are zero and no pop is in flight
- ovf_err  out  1  sticky; set when a push arrives at a channel whose count is DEPTH

## Operation
States are IDLE and SERVE.

**Counters**
- count[i] <= count[i] + push_in[i] - pop[i] every cycle.
- A simultaneous push and pop leaves the count unchanged.
- Push at count == DEPTH: count holds and ovf_err sets. Only reset clears ovf_err.

**Eligibility**
- avail[i] = (count[i] - pop[i]) != 0.
- A push in the current cycle becomes eligible only in the next cycle.

**IDLE**
- pop = 0 and idle = 1.
- Go to SERVE when any avail[i] is set and down_almost_full = 0.

**SERVE, mode 0 (round-robin)**
- Keep grant_ch while avail[grant_ch] is set and burst < MAX_BURST.
- Otherwise rotate: search grant_ch+1, grant_ch+2, … cyclically and take the first avail channel.
- If only the current channel is eligible, keep it and restart the burst.
- burst resets to 1 on each grant change.

**SERVE, mode 1 (strict priority)**
- Grant the lowest-index avail channel every cycle. The burst counter is ignored.

**Both modes**
- While down_almost_full = 1, issue no pop. State and grant_ch hold.
- With no avail channel, return to IDLE. grant_ch holds its last value.
- A change of mode takes effect on the next decision.

## Timing
- **Reset:** pop = 0, push_out = 0, data_out = 0, grant_ch = 0, idle = 1, ovf_err = 0; counts, burst and state (IDLE) are cleared. Reset mid-burst drops the pending pop on the following cycle. The input FIFOs must be reset in the same cycle.
- **Decision latency:** decided at edge k; pop[g], push_out and data_out (= data_in slice g sampled at edge k) are all visible in cycle k+1.
- **Push-to-pop latency:** push_in[i] high in cycle 0 → count = 1 in cycle 1 → pop[i] high in cycle 2 at the earliest.
- **Throughput:** back-to-back pops from one channel sustain 1 word/cycle.
- **Channel switch:** switching channels costs no bubble.
- **Backpressure:** down_almost_full high in cycle k → pop = 0 in cycle k+1.

## Structure
- Shared package arbitro_pkg holds:
  - state encoding: ST_IDLE, ST_SERVE
  - mode constants: MODE_RR = 0, MODE_PRIO = 1
  - width helper for counter and grant widths
- One sub-module, rr_next_sel, finds the next channel (combinational).
  - Inputs: avail vector, start index, mode.
  - Outputs: next index, found flag.
  - Used both for the cyclic search and for the mode-1 lowest-index search.

## Test plan
- **Single word:** push_in = 4'b0100 once → pop = 4'b0100 exactly 2 cycles later; push_out = 1 with data_out = ch2 head; count[2] returns to 0; idle = 1 afterwards.
- **Burst limit (mode 0, MAX_BURST = 4):** preload ch0 with 6 words and ch1 with 2 → pop order ch0 ×4, ch1 ×2, ch0 ×2; grant_ch goes 0,1,0.
- **Skip empty channels:** only ch3 and ch1 loaded, grant_ch = 1 → service order 1, 3, 1, …; channels 0 and 2 are never popped.
- **Strict priority (mode 1):** ch0 and ch3 each hold 3 words, and ch0 is refilled once mid-stream → all 4 ch0 words are popped before any ch3 word.
- **Backpressure:** assert down_almost_full for 3 cycles mid-burst → no pop for 3 cycles starting one cycle later; resumes on the same channel with the burst count held.
- **Overflow and reset:** 9 pushes to ch0 (DEPTH = 8) with down_almost_full held high → count = 8 and ovf_err = 1. Then reset_L = 0 for one edge → all outputs at their reset values, ovf_err = 0.
